mem_stage_lsu: RTL and testbench

Parametrised memory-access pipeline stage that sits between the EX/MEM and MEM/WB boundaries of `ProcessadorPipeline`. It consumes the EX_MEM bundle, performs loads and stores against an internal word-organised data RAM with a configurable number of wait states, and stalls the upstream stages while an access is outstanding. It registers the MEM_WB bundle for write-back, and flags misaligned accesses.

---
 rtl/mem_stage_lsu.sv | 196 +++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage with a wait-stated word RAM, upstream stall and misalign flag.
// Define MEM_SUBWORD_EN for byte/half loads, sign/zero extension and byte-lane stores.
module mem_stage_lsu #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int REG_W       = 5,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EX_MEM_Valid,
    input  logic [DATA_W-1:0] EX_MEM_ALUResult,
    input  logic [DATA_W-1:0] EX_MEM_WriteData,
    input  logic [REG_W-1:0]  EX_MEM_WriteReg,
    input  logic              EX_MEM_MemReadOut,
    input  logic              EX_MEM_MemWriteOut,
    input  logic              EX_MEM_MemtoRegOut,
    input  logic              EX_MEM_RegWrite,
    input  logic [1:0]        EX_MEM_Size,
    input  logic              EX_MEM_Unsigned,
    output logic              mem_stall,
    output logic              MEM_WB_Valid,
    output logic              MEM_WB_RegWrite,
    output logic              MEM_WB_MemtoReg,
    output logic [DATA_W-1:0] MEM_WB_ReadData,
    output logic [DATA_W-1:0] MEM_WB_ALUResult,
    output logic [REG_W-1:0]  MEM_WB_WriteReg,
    output logic              misalign
);

    localparam bit         HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] WS_M1    = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;

    logic [DATA_W-1:0] ram [2**ADDR_W];

    logic [DATA_W-1:0] l_addr, l_wdata;
    logic [REG_W-1:0]  l_wreg;
    logic              l_rd, l_wr, l_m2r, l_rw;

    logic              in_wait, c_valid, c_rd, c_wr, c_m2r, c_rw;
    logic [DATA_W-1:0] c_addr, c_wdata;
    logic [REG_W-1:0]  c_wreg;
    logic              memop, misal, mis, wait_op, complete, ram_we;
    logic [ADDR_W-1:0] widx;
    logic [DATA_W-1:0] rword, ld_data, wr_word, rdata_nx;

    // In WAIT the latched bundle drives everything; upstream may change freely.
    assign in_wait = (state == S_WAIT);
    assign c_valid = in_wait | EX_MEM_Valid;
    assign c_addr  = in_wait ? l_addr  : EX_MEM_ALUResult;
    assign c_wdata = in_wait ? l_wdata : EX_MEM_WriteData;
    assign c_wreg  = in_wait ? l_wreg  : EX_MEM_WriteReg;
    assign c_rd    = in_wait ? l_rd    : EX_MEM_MemReadOut;
    assign c_wr    = in_wait ? l_wr    : EX_MEM_MemWriteOut;
    assign c_m2r   = in_wait ? l_m2r   : EX_MEM_MemtoRegOut;
    assign c_rw    = in_wait ? l_rw    : EX_MEM_RegWrite;

    assign memop = c_valid & (c_rd | c_wr);
    assign mis   = memop & misal;
    assign widx  = c_addr[ADDR_W+1:2];
    assign rword = ram[widx];

`ifdef MEM_SUBWORD_EN
    logic [1:0]        l_size, c_size;
    logic              l_uns, c_uns;
    logic [4:0]        sh;
    logic [15:0]       lane;
    logic [DATA_W-1:0] bmask;

    assign c_size = in_wait ? l_size : EX_MEM_Size;
    assign c_uns  = in_wait ? l_uns  : EX_MEM_Unsigned;
    assign sh     = {c_addr[1:0], 3'b000};
    assign lane   = 16'(rword >> sh);

    always_comb begin
        misal   = 1'b0;
        ld_data = rword;
        bmask   = '1;
        unique case (c_size)
            2'b00: begin
                ld_data = {{(DATA_W-8){lane[7] & ~c_uns}}, lane[7:0]};
                bmask   = {{(DATA_W-8){1'b0}}, 8'hFF} << sh;
            end
            2'b01: begin
                misal   = c_addr[0];
                ld_data = {{(DATA_W-16){lane[15] & ~c_uns}}, lane};
                bmask   = {{(DATA_W-16){1'b0}}, 16'hFFFF} << sh;
            end
            default: misal = (c_addr[1:0] != 2'b00);
        endcase
    end

    assign wr_word = (rword & ~bmask) | ((c_wdata << sh) & bmask);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l_size <= 2'b00;
            l_uns  <= 1'b0;
        end else if (!in_wait) begin
            l_size <= EX_MEM_Size;
            l_uns  <= EX_MEM_Unsigned;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{EX_MEM_Size, EX_MEM_Unsigned};
    assign misal     = (c_addr[1:0] != 2'b00);
    assign ld_data   = rword;
    assign wr_word   = c_wdata;
`endif

    assign wait_op = ~in_wait & memop & ~mis & HAS_WAIT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: if (wait_op) begin
                state_nx = S_WAIT;
                cnt_nx   = WS_M1;
            end
            S_WAIT: if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
                    else             state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        mem_stall = rst & (wait_op | (in_wait & (cnt != 4'd0)));
        complete  = in_wait ? (cnt == 4'd0) : (EX_MEM_Valid & ~wait_op);
        ram_we    = rst & complete & memop & ~mis & c_wr;
        rdata_nx  = (complete & memop & ~mis & ~c_wr) ? ld_data : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l_addr  <= '0;
            l_wdata <= '0;
            l_wreg  <= '0;
            l_rd    <= 1'b0;
            l_wr    <= 1'b0;
            l_m2r   <= 1'b0;
            l_rw    <= 1'b0;
        end else if (!in_wait) begin
            l_addr  <= EX_MEM_ALUResult;
            l_wdata <= EX_MEM_WriteData;
            l_wreg  <= EX_MEM_WriteReg;
            l_rd    <= EX_MEM_MemReadOut;
            l_wr    <= EX_MEM_MemWriteOut;
            l_m2r   <= EX_MEM_MemtoRegOut;
            l_rw    <= EX_MEM_RegWrite;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MEM_WB_Valid     <= 1'b0;
            MEM_WB_RegWrite  <= 1'b0;
            MEM_WB_MemtoReg  <= 1'b0;
            MEM_WB_ReadData  <= '0;
            MEM_WB_ALUResult <= '0;
            MEM_WB_WriteReg  <= '0;
            misalign         <= 1'b0;
        end else begin
            MEM_WB_Valid    <= complete;
            MEM_WB_RegWrite <= complete & c_rw & ~mis;
            misalign        <= complete & mis;
            if (complete) begin
                MEM_WB_MemtoReg  <= c_m2r;
                MEM_WB_ReadData  <= rdata_nx;
                MEM_WB_ALUResult <= c_addr;
                MEM_WB_WriteReg  <= c_wreg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[widx] <= wr_word;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized self-checking bench for mem_stage_lsu.
// The reference keeps a byte-addressed image of the data RAM.
module tb_mem_stage_lsu;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        EX_MEM_Valid;
    logic [31:0] EX_MEM_ALUResult;
    logic [31:0] EX_MEM_WriteData;
    logic [4:0]  EX_MEM_WriteReg;
    logic        EX_MEM_MemReadOut;
    logic        EX_MEM_MemWriteOut;
    logic        EX_MEM_MemtoRegOut;
    logic        EX_MEM_RegWrite;
    logic [1:0]  EX_MEM_Size;
    logic        EX_MEM_Unsigned;
    logic        mem_stall;
    logic        MEM_WB_Valid;
    logic        MEM_WB_RegWrite;
    logic        MEM_WB_MemtoReg;
    logic [31:0] MEM_WB_ReadData;
    logic [31:0] MEM_WB_ALUResult;
    logic [4:0]  MEM_WB_WriteReg;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    logic [7:0] bmem [1024];

    always #5 clk = ~clk;

    mem_stage_lsu #(
        .DATA_W(32), .ADDR_W(8), .REG_W(5), .WAIT_STATES(WS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .EX_MEM_Valid(EX_MEM_Valid),
        .EX_MEM_ALUResult(EX_MEM_ALUResult),
        .EX_MEM_WriteData(EX_MEM_WriteData),
        .EX_MEM_WriteReg(EX_MEM_WriteReg),
        .EX_MEM_MemReadOut(EX_MEM_MemReadOut),
        .EX_MEM_MemWriteOut(EX_MEM_MemWriteOut),
        .EX_MEM_MemtoRegOut(EX_MEM_MemtoRegOut),
        .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_Size(EX_MEM_Size),
        .EX_MEM_Unsigned(EX_MEM_Unsigned),
        .mem_stall(mem_stall),
        .MEM_WB_Valid(MEM_WB_Valid),
        .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .MEM_WB_MemtoReg(MEM_WB_MemtoReg),
        .MEM_WB_ReadData(MEM_WB_ReadData),
        .MEM_WB_ALUResult(MEM_WB_ALUResult),
        .MEM_WB_WriteReg(MEM_WB_WriteReg),
        .misalign(misalign)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, wd,
                         input logic [4:0] r, input logic rd, wr, m2r, rw,
                         input logic [1:0] sz, input logic uns);
        EX_MEM_Valid       = v;
        EX_MEM_ALUResult   = a;
        EX_MEM_WriteData   = wd;
        EX_MEM_WriteReg    = r;
        EX_MEM_MemReadOut  = rd;
        EX_MEM_MemWriteOut = wr;
        EX_MEM_MemtoRegOut = m2r;
        EX_MEM_RegWrite    = rw;
        EX_MEM_Size        = sz;
        EX_MEM_Unsigned    = uns;
    endtask

    task automatic drive_garbage();
        drive(1'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
              1'($urandom));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, MEM_WB_Valid, 0);
        chk({tag, "_regwrite"}, MEM_WB_RegWrite, 0);
        chk({tag, "_memtoreg"}, MEM_WB_MemtoReg, 0);
        chk({tag, "_rdata"}, MEM_WB_ReadData, 0);
        chk({tag, "_alu"}, MEM_WB_ALUResult, 0);
        chk({tag, "_wreg"}, MEM_WB_WriteReg, 0);
        chk({tag, "_misalign"}, misalign, 0);
        chk({tag, "_stall"}, mem_stall, 0);
    endtask

    // Presents one bundle at a negedge, holds it (random junk once stalled),
    // and checks stall, bubbles and the final MEM_WB bundle. Ends at a negedge.
    task automatic do_op(input logic v, input logic [31:0] a, wd,
                         input logic [4:0] r, input logic rd, wr, m2r, rw,
                         input logic [1:0] sz, input logic uns);
        int unsigned nb;
        logic        memop, mis;
        logic [31:0] val, exp_rd;
        logic [9:0]  base;
        int          cyc;
        memop = v && (rd || wr);
`ifdef MEM_SUBWORD_EN
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`else
        nb = 4;
`endif
        mis    = memop && ((a % nb) != 0);
        base   = a[9:0];
        val    = 32'd0;
        exp_rd = 32'd0;
        if (memop && !mis) begin
            for (int k = 0; k < int'(nb); k++)
                val[8*k +: 8] = bmem[int'(base) + k];
`ifdef MEM_SUBWORD_EN
            if (!uns && nb < 4 && val[8*nb-1])
                for (int k = int'(nb); k < 4; k++) val[8*k +: 8] = 8'hFF;
`endif
            if (wr) begin
                for (int k = 0; k < int'(nb); k++)
                    bmem[int'(base) + k] = wd[8*k +: 8];
            end else begin
                exp_rd = val;
            end
        end
        cyc = (memop && !mis && WS > 0) ? WS + 1 : 1;
        for (int i = 0; i < cyc; i++) begin
            if (i == 0) drive(v, a, wd, r, rd, wr, m2r, rw, sz, uns);
            else        drive_garbage();
            #1;
            chk("stall", mem_stall, (memop && !mis && i < WS));
            @(negedge clk);
            if (i < cyc - 1) begin
                chk("bubble_valid", MEM_WB_Valid, 0);
                chk("bubble_regwrite", MEM_WB_RegWrite, 0);
            end
        end
        chk("valid", MEM_WB_Valid, v);
        chk("regwrite", MEM_WB_RegWrite, (v && rw && !mis));
        chk("misalign", misalign, mis);
        if (v) begin
            chk("alu", MEM_WB_ALUResult, a);
            chk("wreg", MEM_WB_WriteReg, r);
            chk("memtoreg", MEM_WB_MemtoReg, m2r);
            chk("rdata", MEM_WB_ReadData, exp_rd);
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0);
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b1;

        for (int w = 0; w < 256; w++)
            do_op(1, 32'(w * 4), $urandom, 5'($urandom), 0, 1, 0, 0, 2'd2, 0);

        do_op(1, 32'h10, 32'hDEADBEEF, 0, 0, 1, 0, 0, 2'd2, 0);
        do_op(1, 32'h10, 32'h0, 5, 1, 0, 1, 1, 2'd2, 0);
        chk("tp_load_word", MEM_WB_ReadData, 32'hDEADBEEF);
        do_op(1, 32'h2A, 32'h0, 7, 0, 0, 0, 1, 2'd2, 0);

        do_op(1, 32'h10, 32'h80FF7F01, 0, 0, 1, 0, 0, 2'd2, 0);
        do_op(1, 32'h13, 32'h0, 3, 1, 0, 1, 1, 2'd0, 0);
        do_op(1, 32'h13, 32'h0, 3, 1, 0, 1, 1, 2'd0, 1);
        do_op(1, 32'h12, 32'h00001234, 0, 0, 1, 0, 0, 2'd1, 0);
        do_op(1, 32'h10, 32'h0, 4, 1, 0, 1, 1, 2'd2, 0);

        do_op(1, 32'h11, 32'h0, 6, 1, 0, 1, 1, 2'd2, 0);
        do_op(1, 32'h21, 32'h55555555, 0, 0, 1, 0, 0, 2'd2, 0);
        do_op(1, 32'h20, 32'h0, 8, 1, 0, 1, 1, 2'd2, 0);
        do_op(0, 32'h30, 32'hAAAAAAAA, 0, 0, 1, 0, 1, 2'd2, 0);
        do_op(1, 32'h30, 32'h0, 9, 1, 1, 0, 1, 2'd2, 0);
        do_op(1, 32'h30, 32'h0, 9, 1, 0, 1, 1, 2'd2, 0);

        // Store to 0x20 aborted by reset in its second wait cycle.
        do_op(1, 32'h2A, 32'h0, 7, 0, 0, 0, 1, 2'd2, 0);
        drive(1, 32'h20, 32'hCAFEF00D, 3, 0, 1, 0, 0, 2'd2, 0);
        #1 chk("abort_stall", mem_stall, 1);
        @(negedge clk);
        drive_garbage();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0);
        rst = 1'b0;
        #1 check_reset("abort");
        @(negedge clk);
        rst = 1'b1;
        do_op(1, 32'h20, 32'h0, 10, 1, 0, 1, 1, 2'd2, 0);

        do_op(1, 32'h400, 32'h13572468, 0, 0, 1, 0, 0, 2'd2, 0);
        do_op(1, 32'h000, 32'h0, 11, 1, 0, 1, 1, 2'd2, 0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            int          kind;
            kind = $urandom_range(0, 3);
            a = ($urandom_range(0, 3) == 0) ? $urandom
                                            : 32'($urandom_range(0, 1023));
            do_op(($urandom_range(0, 9) != 0), a, $urandom, 5'($urandom),
                  (kind == 1 || kind == 3), (kind == 2 || kind == 3),
                  1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
